alu_bist: RTL and testbench

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_bist.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// alu_bist: built-in self test for a 32-bit single-cycle ALU.
// Drives operand pairs (three fixed corner vectors, then LFSR-generated
// vectors) through AND, OR, ADD, SUB, SLT and NOR. Each ALU answer is
// compared against an internally computed expected result and zero flag.
// Mismatches are counted, and the first one is recorded.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             run request, accepted in IDLE or DONE
//   a, b, ALUControl  registered stimulus to the ALU (0 in IDLE/DONE)
//   ALUResult, zero   ALU response, checked in CHECK
//   busy, done, pass  run status
//   fail_count        saturating mismatch count for the current run
//   first_fail_index  vector index of the first mismatch
//   first_fail_op     ALUControl code of the first mismatch
module alu_bist #(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [31:0] SEED        = 32'hACE12468
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  ALUControl,
    input  logic [31:0] ALUResult,
    input  logic        zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output logic [15:0] first_fail_index,
    output logic [3:0]  first_fail_op
);

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned OPW  = 4;
    localparam int unsigned OPIW = 3;

    localparam logic [DW-1:0]   SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [CW-1:0]   VEC_LAST = CW'(NUM_VECTORS - 1);
    localparam logic [OPIW-1:0] OP_LAST  = OPIW'(5);
    localparam logic [CW-1:0]   CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Fibonacci LFSR, taps 32,22,2,1; shift left, feedback into bit 0
    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    // Op index within a vector -> ALUControl code
    function automatic logic [OPW-1:0] op_code(input logic [OPIW-1:0] idx);
        logic [OPW-1:0] c;
        case (idx)
            3'd0:    c = 4'b0000;
            3'd1:    c = 4'b0001;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0111;
            3'd5:    c = 4'b1100;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [OPW-1:0]  ctrl_q, ctrl_d;
    logic [DW-1:0]   lfsr_q, lfsr_d;
    logic [CW-1:0]   vec_q, vec_d;
    logic [OPIW-1:0] op_q, op_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [CW-1:0]   fail_count_q, fail_count_d;
    logic [CW-1:0]   ff_index_q, ff_index_d;
    logic [OPW-1:0]  ff_op_q, ff_op_d;

    logic [DW-1:0]   exp_res_c;
    logic            exp_zero_c;
    logic            mismatch_c;
    logic            load_c;
    logic [DW-1:0]   step1_c;
    logic [DW-1:0]   step2_c;

    // Reference result for the operands currently presented to the ALU
    always_comb begin
        exp_res_c = '0;
        case (ctrl_q)
            4'b0000: exp_res_c = a_q & b_q;
            4'b0001: exp_res_c = a_q | b_q;
            4'b0010: exp_res_c = a_q + b_q;
            4'b0110: exp_res_c = a_q - b_q;
            4'b0111: exp_res_c = DW'($signed(a_q) < $signed(b_q));
            4'b1100: exp_res_c = ~(a_q | b_q);
            default: exp_res_c = '0;
        endcase
        exp_zero_c = (exp_res_c == '0);
        mismatch_c = (ALUResult != exp_res_c) || (zero != exp_zero_c);
    end

    // Next-state, counters, operand generation and status
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        lfsr_d       = lfsr_q;
        vec_d        = vec_q;
        op_d         = op_q;
        fail_count_d = fail_count_q;
        ff_index_d   = ff_index_q;
        ff_op_d      = ff_op_q;
        load_c       = 1'b0;
        step1_c      = '0;
        step2_c      = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    lfsr_d       = SEED_EFF;
                    vec_d        = '0;
                    op_d         = '0;
                    fail_count_d = '0;
                    ff_index_d   = '0;
                    ff_op_d      = '0;
                    load_c       = 1'b1;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch_c) begin
                    // A zero count means no earlier mismatch in this run
                    if (fail_count_q == '0) begin
                        ff_index_d = vec_q;
                        ff_op_d    = ctrl_q;
                    end
                    if (fail_count_q != CNT_MAX) begin
                        fail_count_d = fail_count_q + 16'd1;
                    end
                end
                if ((vec_q == VEC_LAST) && (op_q == OP_LAST)) begin
                    state_d = S_DONE;
                    a_d     = '0;
                    b_d     = '0;
                    ctrl_d  = '0;
                end else begin
                    state_d = S_DRIVE;
                    load_c  = 1'b1;
                    if (op_q == OP_LAST) begin
                        op_d  = '0;
                        vec_d = vec_q + 16'd1;
                    end else begin
                        op_d = op_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operands change only at the first op of each vector
        if (load_c) begin
            ctrl_d = op_code(op_d);
            if (op_d == '0) begin
                case (vec_d)
                    16'd0: begin a_d = 32'h0000_0000; b_d = 32'h0000_0000; end
                    16'd1: begin a_d = 32'hFFFF_FFFF; b_d = 32'h0000_0001; end
                    16'd2: begin a_d = 32'h8000_0000; b_d = 32'h7FFF_FFFF; end
                    default: begin
                        step1_c = lfsr_step(lfsr_d);
                        step2_c = lfsr_step(step1_c);
                        a_d     = step1_c;
                        b_d     = step2_c;
                        lfsr_d  = step2_c;
                    end
                endcase
            end
        end

        busy_d = (state_d == S_DRIVE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (fail_count_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            lfsr_q       <= SEED_EFF;
            vec_q        <= '0;
            op_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            ff_index_q   <= '0;
            ff_op_q      <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            lfsr_q       <= lfsr_d;
            vec_q        <= vec_d;
            op_q         <= op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            ff_index_q   <= ff_index_d;
            ff_op_q      <= ff_op_d;
        end
    end

    assign a                = a_q;
    assign b                = b_q;
    assign ALUControl       = ctrl_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_count_q;
    assign first_fail_index = ff_index_q;
    assign first_fail_op    = ff_op_q;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed bench for alu_bist with a behavioural ALU that can
// inject faults (mode 0 ideal, 1 SLT bit 0 forced low, 2 zero tied low).
module tb_alu_bist;

    localparam int unsigned NV   = 4;
    localparam logic [31:0] SEED = 32'hACE12468;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        zero;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] fail_count;
    logic [15:0] first_fail_index;
    logic [3:0]  first_fail_op;

    int errors;
    int checks;
    int fault_mode;

    alu_bist #(.NUM_VECTORS(NV), .SEED(SEED)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .a                (a),
        .b                (b),
        .ALUControl       (ALUControl),
        .ALUResult        (ALUResult),
        .zero             (zero),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_index (first_fail_index),
        .first_fail_op    (first_fail_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU with optional fault injection
    always_comb begin
        ALUResult = 32'h0;
        case (ALUControl)
            4'b0000: ALUResult = a & b;
            4'b0001: ALUResult = a | b;
            4'b0010: ALUResult = a + b;
            4'b0110: ALUResult = a - b;
            4'b0111: ALUResult = {31'h0, $signed(a) < $signed(b)};
            4'b1100: ALUResult = ~(a | b);
            default: ALUResult = 32'h0;
        endcase
        if (fault_mode == 1 && ALUControl == 4'b0111) ALUResult[0] = 1'b0;
        zero = (fault_mode == 2) ? 1'b0 : (ALUResult == 32'h0);
    end

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [3:0] ref_op(input int k);
        case (k)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            default: return 4'b1100;
        endcase
    endfunction

    // Full run from a start pulse: checks every DRIVE/CHECK cycle and the
    // DONE arrival at exactly 12*NV edges after the start edge.
    // glitch >= 0 raises start during that check's CHECK cycle.
    task automatic do_run(input int mode, input int glitch);
        logic [31:0] l, ea, eb;
        logic [3:0]  eop;
        fault_mode = mode;
        l = SEED;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int v = 0; v < int'(NV); v++) begin
            case (v)
                0: begin ea = 32'h0000_0000; eb = 32'h0000_0000; end
                1: begin ea = 32'hFFFF_FFFF; eb = 32'h0000_0001; end
                2: begin ea = 32'h8000_0000; eb = 32'h7FFF_FFFF; end
                default: begin ea = ref_step(l); eb = ref_step(ea); l = eb; end
            endcase
            for (int k = 0; k < 6; k++) begin
                eop = ref_op(k);
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL drive_status v=%0d k=%0d busy=%b done=%b want busy=1 done=0", v, k, busy, done);
                end
                checks++;
                if (a !== ea || b !== eb || ALUControl !== eop) begin
                    errors++;
                    $display("FAIL drive_operands v=%0d k=%0d got a=%h b=%h op=%b want a=%h b=%h op=%b",
                             v, k, a, b, ALUControl, ea, eb, eop);
                end
                @(posedge clk); #1;
                if (glitch == v * 6 + k) start = 1'b1;
                checks++;
                if (a !== ea || b !== eb || ALUControl !== eop || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL check_hold v=%0d k=%0d got a=%h b=%h op=%b busy=%b done=%b want a=%h b=%h op=%b busy=1 done=0",
                             v, k, a, b, ALUControl, busy, done, ea, eb, eop);
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || a !== 32'h0 || b !== 32'h0 || ALUControl !== 4'h0) begin
            errors++;
            $display("FAIL done_entry got done=%b busy=%b a=%h b=%h op=%b want done=1 busy=0 a=0 b=0 op=0",
                     done, busy, a, b, ALUControl);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || a !== 32'h0 || b !== 32'h0 ||
            ALUControl !== 4'h0 || fail_count !== 16'h0 || first_fail_index !== 16'h0 || first_fail_op !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b pass=%b a=%h b=%h op=%b fc=%h ffi=%h ffo=%b want all 0",
                     busy, done, pass, a, b, ALUControl, fail_count, first_fail_index, first_fail_op);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_ideal_run();
        do_run(0, -1);
        checks++;
        if (pass !== 1'b1 || fail_count !== 16'h0 || first_fail_index !== 16'h0 || first_fail_op !== 4'h0) begin
            errors++;
            $display("FAIL ideal_result got pass=%b fc=%0d ffi=%0d ffo=%b want pass=1 fc=0 ffi=0 ffo=0000",
                     pass, fail_count, first_fail_index, first_fail_op);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
        end
    endtask

    task automatic test_slt_fault();
        do_run(1, -1);
        checks++;
        if (first_fail_index !== 16'd1 || first_fail_op !== 4'b0111 || pass !== 1'b0 || fail_count < 16'd2) begin
            errors++;
            $display("FAIL slt_fault got ffi=%0d ffo=%b pass=%b fc=%0d want ffi=1 ffo=0111 pass=0 fc>=2",
                     first_fail_index, first_fail_op, pass, fail_count);
        end
    endtask

    task automatic test_zero_tied();
        do_run(2, -1);
        checks++;
        if (first_fail_index !== 16'd0 || first_fail_op !== 4'b0000 || pass !== 1'b0 || fail_count < 16'd9) begin
            errors++;
            $display("FAIL zero_tied got ffi=%0d ffo=%b pass=%b fc=%0d want ffi=0 ffo=0000 pass=0 fc>=9",
                     first_fail_index, first_fail_op, pass, fail_count);
        end
    endtask

    task automatic test_restart_from_done();
        do_run(0, -1);
        checks++;
        if (pass !== 1'b1 || fail_count !== 16'h0 || first_fail_index !== 16'h0 || first_fail_op !== 4'h0) begin
            errors++;
            $display("FAIL restart_clear got pass=%b fc=%0d ffi=%0d ffo=%b want pass=1 fc=0 ffi=0 ffo=0000",
                     pass, fail_count, first_fail_index, first_fail_op);
        end
    endtask

    task automatic test_start_in_check();
        do_run(0, 7);
        checks++;
        if (pass !== 1'b1 || fail_count !== 16'h0) begin
            errors++;
            $display("FAIL start_in_check got pass=%b fc=%0d want pass=1 fc=0", pass, fail_count);
        end
    endtask

    task automatic test_reset_midrun();
        fault_mode = 2;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || fail_count === 16'h0) begin
            errors++;
            $display("FAIL midrun_pre got busy=%b fc=%0d want busy=1 fc>0", busy, fail_count);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || a !== 32'h0 || b !== 32'h0 ||
            ALUControl !== 4'h0 || fail_count !== 16'h0 || first_fail_index !== 16'h0 || first_fail_op !== 4'h0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b pass=%b a=%h b=%h op=%b fc=%h ffi=%h ffo=%b want all 0",
                     busy, done, pass, a, b, ALUControl, fail_count, first_fail_index, first_fail_op);
        end
        do_run(0, -1);
        checks++;
        if (pass !== 1'b1 || fail_count !== 16'h0) begin
            errors++;
            $display("FAIL midrun_restart got pass=%b fc=%0d want pass=1 fc=0", pass, fail_count);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        fault_mode = 0;
        reset      = 1'b1;
        start      = 1'b0;
        test_reset();
        test_ideal_run();
        test_slt_fault();
        test_zero_tied();
        test_restart_from_done();
        test_start_in_check();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
